// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch front end: machine width, canonical NOP
// and the fetch controller state encoding.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble (NOP, invalid) while keeping
// the PC fields; hold freezes every field.
module if_id_reg
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] NOP = NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            hold,
   input  logic            flush,
   input  logic [XLEN-1:0] cap_pc,
   input  logic [XLEN-1:0] cap_instr,
   output logic            id_valid,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_pc_plus4,
   output logic [XLEN-1:0] id_instr
);

   logic            vld_p1;
   logic [XLEN-1:0] pc_p1;
   logic [XLEN-1:0] pc4_p1;
   logic [XLEN-1:0] instr_p1;

   // ---- IF -> ID boundary ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1   <= 1'b0;
         pc_p1    <= '0;
         pc4_p1   <= '0;
         instr_p1 <= NOP;
      end else if (flush) begin
         vld_p1   <= 1'b0;
         instr_p1 <= NOP;
      end else if (!hold) begin
         vld_p1   <= 1'b1;
         pc_p1    <= cap_pc;
         pc4_p1   <= cap_pc + 32'd4;
         instr_p1 <= cap_instr;
      end
   end

   assign id_valid    = vld_p1;
   assign id_pc       = pc_p1;
   assign id_pc_plus4 = pc4_p1;
   assign id_instr    = instr_p1;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address,
// handles stall/redirect/fault and counts retired fetches.
module if_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] IMEM_BYTES = 32'd32768,
   parameter logic [31:0] NOP_INSTR  = riscv_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4,
   output logic [31:0] id_instr,
   output logic        fetch_fault,
   output logic [31:0] fetch_count
);

   riscv_pkg::fetch_state_e state;
   logic [31:0] pc_p0;
   logic        fault_q;
   logic [31:0] fetch_count_q;
   logic        in_range;
   logic        misaligned;
   logic        flush;
   logic        capture;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_comb begin
      in_range   = (pc_p0 < IMEM_BYTES);
      misaligned = (redirect_pc[1:0] != 2'b00);
      flush      = 1'b0;
      capture    = 1'b0;
      if (state == riscv_pkg::RUN) begin
         if (redirect_valid || !in_range) flush = 1'b1;
         else if (!stall)                 capture = 1'b1;
      end
   end

   // ---- PC / control boundary ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= riscv_pkg::BOOT;
         pc_p0         <= RESET_PC;
         fault_q       <= 1'b0;
         fetch_count_q <= '0;
      end else begin
         case (state)
            riscv_pkg::BOOT: state <= riscv_pkg::RUN;
            riscv_pkg::RUN: begin
               if (redirect_valid) begin
                  if (misaligned) begin
                     fault_q <= 1'b1;
                     state   <= riscv_pkg::HALT;
                  end else begin
                     pc_p0 <= redirect_pc;
                  end
               end else if (!in_range) begin
                  fault_q <= 1'b1;
                  state   <= riscv_pkg::HALT;
               end else if (!stall) begin
                  pc_p0         <= pc_p0 + 32'd4;
                  fetch_count_q <= sat_inc(fetch_count_q);
               end
            end
            default: state <= riscv_pkg::HALT;
         endcase
      end
   end

   if_id_reg #(
      .NOP (NOP_INSTR)
   ) u_if_id (
      .clk         (clk),
      .rst_n       (rst_n),
      .hold        (!capture),
      .flush       (flush),
      .cap_pc      (pc_p0),
      .cap_instr   (imem_rdata),
      .id_valid    (id_valid),
      .id_pc       (id_pc),
      .id_pc_plus4 (id_pc_plus4),
      .id_instr    (id_instr)
   );

   assign imem_addr   = pc_p0;
   assign fetch_fault = fault_q;
   assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: byte-wide instruction memory model, linear
// stimulus with hand-computed expectations.
module tb_if_stage;

   logic        clk;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   logic [31:0] id_instr;
   logic        fetch_fault;
   logic [31:0] fetch_count;

   int vectors = 0;
   int errors  = 0;

   logic [7:0] mem [0:32767];

   if_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_pc          (id_pc),
      .id_pc_plus4    (id_pc_plus4),
      .id_instr       (id_instr),
      .fetch_fault    (fetch_fault),
      .fetch_count    (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Big-endian read: MSB byte sits at imem_addr; out of range returns X.
   always_comb begin
      if (imem_addr < 32'd32768)
         imem_rdata = {mem[imem_addr[14:0]], mem[imem_addr[14:0] + 15'd1],
                       mem[imem_addr[14:0] + 15'd2], mem[imem_addr[14:0] + 15'd3]};
      else
         imem_rdata = 'x;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int a = 0; a < 32768; a++) mem[a] = 8'(a) + 8'h40;
      mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h13;
      mem[4] = 8'h00; mem[5] = 8'h10; mem[6] = 8'h00; mem[7] = 8'h93;

      rst_n          = 1'b0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      #12;
      chk("rst_valid", {31'd0, id_valid}, 32'd0);
      chk("rst_instr", id_instr, 32'h0000_0013);
      chk("rst_pc", id_pc, 32'd0);
      chk("rst_pc4", id_pc_plus4, 32'd0);
      chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
      chk("rst_count", fetch_count, 32'd0);
      chk("rst_addr", imem_addr, 32'd0);

      edge1();
      rst_n = 1'b1;
      // Redirect during BOOT must be ignored.
      redirect_valid = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
      edge1();
      chk("boot_valid", {31'd0, id_valid}, 32'd0);
      chk("boot_addr", imem_addr, 32'd0);
      redirect_valid = 1'b0; stall = 1'b0;

      edge1();
      chk("f0_instr", id_instr, 32'h0000_0013);
      chk("f0_pc", id_pc, 32'd0);
      chk("f0_pc4", id_pc_plus4, 32'd4);
      chk("f0_valid", {31'd0, id_valid}, 32'd1);
      edge1();
      chk("f1_instr", id_instr, 32'h0010_0093);
      chk("f1_pc", id_pc, 32'd4);
      chk("f1_count", fetch_count, 32'd2);
      edge1();
      chk("f2_pc", id_pc, 32'd8);
      chk("f2_instr", id_instr, 32'h4849_4A4B);
      chk("f2_addr", imem_addr, 32'hC);

      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         edge1();
         chk("stl_addr", imem_addr, 32'hC);
         chk("stl_pc", id_pc, 32'd8);
         chk("stl_instr", id_instr, 32'h4849_4A4B);
         chk("stl_count", fetch_count, 32'd3);
         chk("stl_valid", {31'd0, id_valid}, 32'd1);
      end
      stall = 1'b0;
      edge1();
      chk("res_pc", id_pc, 32'hC);
      chk("res_instr", id_instr, 32'h4C4D_4E4F);
      chk("res_count", fetch_count, 32'd4);

      redirect_valid = 1'b1; redirect_pc = 32'h100; stall = 1'b1;
      edge1();
      chk("rd_valid", {31'd0, id_valid}, 32'd0);
      chk("rd_instr", id_instr, 32'h0000_0013);
      chk("rd_pc_hold", id_pc, 32'hC);
      chk("rd_pc4_hold", id_pc_plus4, 32'h10);
      chk("rd_addr", imem_addr, 32'h100);
      chk("rd_count", fetch_count, 32'd4);
      redirect_valid = 1'b0; stall = 1'b0;
      edge1();
      chk("tgt_pc", id_pc, 32'h100);
      chk("tgt_valid", {31'd0, id_valid}, 32'd1);
      chk("tgt_instr", id_instr, 32'h4041_4243);
      chk("tgt_count", fetch_count, 32'd5);

      stall = 1'b1;
      edge1();
      force dut.fetch_count_q = 32'hFFFF_FFFE;
      #1;
      release dut.fetch_count_q;
      stall = 1'b0;
      edge1();
      chk("sat_1", fetch_count, 32'hFFFF_FFFF);
      edge1();
      chk("sat_2", fetch_count, 32'hFFFF_FFFF);
      edge1();
      chk("sat_3", fetch_count, 32'hFFFF_FFFF);

      redirect_valid = 1'b1; redirect_pc = 32'h7FF8;
      edge1();
      redirect_valid = 1'b0;
      edge1();
      chk("top_pc0", id_pc, 32'h7FF8);
      chk("top_instr0", id_instr, 32'h3839_3A3B);
      edge1();
      chk("top_pc1", id_pc, 32'h7FFC);
      chk("top_pc4", id_pc_plus4, 32'h8000);
      chk("top_addr", imem_addr, 32'h8000);
      edge1();
      chk("oor_fault", {31'd0, fetch_fault}, 32'd1);
      chk("oor_valid", {31'd0, id_valid}, 32'd0);
      chk("oor_instr", id_instr, 32'h0000_0013);
      chk("oor_pc_hold", id_pc, 32'h7FFC);
      chk("oor_addr", imem_addr, 32'h8000);
      edge1();
      chk("oor_halt_instr", id_instr, 32'h0000_0013);
      chk("oor_halt_addr", imem_addr, 32'h8000);

      #2;
      rst_n = 1'b0;
      #1;
      chk("rst2_fault", {31'd0, fetch_fault}, 32'd0);
      chk("rst2_addr", imem_addr, 32'd0);
      chk("rst2_count", fetch_count, 32'd0);
      edge1();
      rst_n = 1'b1;
      edge1();
      redirect_valid = 1'b1; redirect_pc = 32'h102;
      edge1();
      chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
      chk("mis_valid", {31'd0, id_valid}, 32'd0);
      chk("mis_addr", imem_addr, 32'd0);
      redirect_pc = 32'h200;
      edge1();
      chk("halt_addr", imem_addr, 32'd0);
      chk("halt_fault", {31'd0, fetch_fault}, 32'd1);
      chk("halt_valid", {31'd0, id_valid}, 32'd0);
      redirect_valid = 1'b0;
      edge1();
      chk("halt_count", fetch_count, 32'd0);
      chk("halt_addr2", imem_addr, 32'd0);

      #2;
      rst_n = 1'b0;
      #1;
      chk("rst3_fault", {31'd0, fetch_fault}, 32'd0);
      chk("rst3_addr", imem_addr, 32'd0);
      chk("rst3_instr", id_instr, 32'h0000_0013);
      rst_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
